uart_prog_loader: RTL
=====================

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 Parameter CLK_HZ, default 10_000_000, is the clock frequency in Hz.
REQ-002 Parameter BAUD, default 128_000, is the UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD, integer division.
REQ-003 Parameter TIMEOUT_CYCLES, default 1_000_000, is the mid-frame inactivity limit in clocks.
REQ-004 Port clock  input  1  is the single clock; all logic is on posedge.
REQ-005 Port reset  input  1  is a synchronous, active-high reset.
REQ-006 Port rx_i  input  1  is the UART serial line, 8N1, idle high, asynchronous to clock.
REQ-007 Port upg_wen_o  output  1  is the one-cycle memory write strobe.
REQ-008 Port upg_adr_o  output  15  is the write address: bit 14 = segment (0 instruction ROM, 1 data RAM), bits 13:0 = word index.
REQ-009 Port upg_dat_o  output  32  is the write data word.
REQ-010 Port upg_done_o  output  1  is high when the programme is finished and sticky until reset.
REQ-011 Port upg_err_o  output  1  is a sticky error flag.
REQ-012 Port busy_o  output  1  is high while in any state other than S_CMD or S_DONE.

Function
REQ-013 rx_i SHALL pass through a 2-flop synchroniser before any use.
REQ-014 Receiver behaviour:
- Start is detected on the falling edge and re-checked low at CLKS_PER_BIT/2.
- Data bits are sampled at bit centres, LSB first.
- A byte_valid pulse lasts one clock after the stop-bit sample.
REQ-015 A stop bit sampled low SHALL discard the byte, produce no byte_valid, and set upg_err_o.
REQ-016 Frame format: CMD byte; for 0x00/0x01, LEN_LO then LEN_HI (word count N, little-endian); then 4N data bytes, each word little-endian.
REQ-017 FSM states are S_CMD, S_LEN0, S_LEN1, S_DATA, S_DONE.
REQ-018 S_CMD transitions on a byte:
- 0x00 -> S_LEN0 with segment=0.
- 0x01 -> S_LEN0 with segment=1.
- 0xFF -> S_DONE.
- Any other value: ignored, stays in S_CMD, no error.
REQ-019 S_LEN0 captures LEN_LO and goes to S_LEN1.
REQ-020 S_LEN1 captures LEN_HI, then:
- N=0 -> S_CMD.
- N>16384 -> N saturates to 16384, upg_err_o set.
- Otherwise -> S_DATA.
REQ-021 Entering S_DATA SHALL clear the word index and byte counter.
REQ-022 In S_DATA the 4th byte of a word SHALL assert upg_wen_o on the next clock for exactly 1 cycle, with upg_adr_o and upg_dat_o valid in that same cycle.
REQ-023 The word index increments after each write; after the Nth write the FSM returns to S_CMD.
REQ-024 Outside write cycles, upg_wen_o=0; upg_adr_o and upg_dat_o hold their last values.
REQ-025 If S_LEN0, S_LEN1 or S_DATA sees no byte_valid for TIMEOUT_CYCLES consecutive clocks, the FSM SHALL:
- return to S_CMD,
- discard any partial word,
- set upg_err_o.
REQ-026 S_DONE asserts upg_done_o and ignores all further bytes until reset.
REQ-027 The receiver runs continuously; a byte arriving on the same clock as a timeout expiry is dropped (timeout wins).

Reset
REQ-028 On reset all outputs SHALL be 0: upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, upg_err_o, busy_o.
REQ-029 On reset the FSM goes to S_CMD, the receiver to idle, and all counters to 0.
REQ-030 Reset asserted mid-byte or mid-word SHALL abort with no write; a resumed line mid-byte is resynchronised at the next start bit.

Structure
REQ-031 A shared package or defines file SHALL hold the command codes (CMD_IROM 8'h00, CMD_DRAM 8'h01, CMD_DONE 8'hFF), the FSM state encodings and the segment bit index 14.
REQ-032 One sub-module, uart_rx, SHALL hold the synchroniser, baud counter and shift register, with outputs byte_o[7:0], byte_valid_o and frame_err_o.

Verification
REQ-033 All scenarios SHALL use CLK_HZ=10_000_000, BAUD=1_000_000 (10 clocks/bit) and TIMEOUT_CYCLES=500.
REQ-034 Scenario 1, instruction load:
- Stimulus: bytes 00 02 00 78 56 34 12 EF BE AD DE.
- Response: writes adr 0x0000 dat 0x12345678, then adr 0x0001 dat 0xDEADBEEF; exactly 2 upg_wen_o pulses; back in S_CMD.
REQ-035 Scenario 2, data load then finish:
- Stimulus: bytes 01 01 00 44 33 22 11 FF.
- Response: write adr 0x4000 dat 0x11223344; upg_done_o=1 and stays 1.
- Follow-up: a further 00 01 00 … after done produces no writes.
REQ-036 Scenario 3, timeout:
- Stimulus: 00 01 00 AA BB, then idle for 600 clocks.
- Response: no write, upg_err_o=1, FSM in S_CMD.
- Follow-up: 00 01 00 01 02 03 04 writes adr 0x0000 dat 0x04030201.
REQ-037 Scenario 4, framing error:
- Stimulus: byte 0x00 with stop bit driven low.
- Response: byte dropped, upg_err_o=1, FSM remains in S_CMD.
REQ-038 Scenario 5, zero length, unknown command and reset:
- Stimulus: 00 00 00.
- Response: no write, returns to S_CMD.
- Stimulus: byte 0x55.
- Response: ignored, upg_err_o stays 0.
- Stimulus: reset pulsed mid-word during 00 01 00 11 22.
- Response: no write, all outputs 0.

Source files
------------

// File: rtl/uart_prog_loader_pkg.sv
// rtl/uart_prog_loader_pkg.sv - shared command codes, state encodings and address layout for the UART programme loader
package uart_prog_loader_pkg;

    localparam logic [7:0] CMD_IROM = 8'h00;
    localparam logic [7:0] CMD_DRAM = 8'h01;
    localparam logic [7:0] CMD_DONE = 8'hFF;

    // Bit of upg_adr_o that selects instruction ROM (0) or data RAM (1)
    localparam int SEG_BIT   = 14;
    // Largest word count a single load may request; larger requests saturate
    localparam int MAX_WORDS = 16384;

    typedef enum logic [2:0] {
        S_CMD  = 3'd0,
        S_LEN0 = 3'd1,
        S_LEN1 = 3'd2,
        S_DATA = 3'd3,
        S_DONE = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_prog_loader_rx.sv
// rtl/uart_prog_loader_rx.sv - 8N1 UART receiver with input synchroniser and stop-bit check
module uart_rx
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 78
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int HALF_M1_I = (CLKS_PER_BIT / 2 > 0) ? (CLKS_PER_BIT / 2 - 1) : 0;
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF_M1_I);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic            sync1_q, sync2_q, prev_q;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection; idles high
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Receiver state, baud counter and shift register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Start detect on falling edge, confirm at half bit, then sample each bit centre
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A glitch that is high again by mid-bit is not a start bit
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (sync2_q) begin
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART framed programme loader writing 32-bit words into ROM/RAM
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int CLK_HZ         = 10_000_000,
    parameter int BAUD           = 128_000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_i,
    output logic        upg_wen_o,
    output logic [14:0] upg_adr_o,
    output logic [31:0] upg_dat_o,
    output logic        upg_done_o,
    output logic        upg_err_o,
    output logic        busy_o
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
    localparam logic [15:0] MAX_N16 = 16'(MAX_WORDS);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock       (clock),
        .reset       (reset),
        .rx_i        (rx_i),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_valid),
        .frame_err_o (rx_ferr)
    );

    state_e         state_q, state_d;
    logic           seg_q, seg_d;
    logic [7:0]     len_lo_q, len_lo_d;
    logic [14:0]    len_q, len_d;
    logic [14:0]    widx_q, widx_d;
    logic [1:0]     bcnt_q, bcnt_d;
    logic [31:0]    word_q, word_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic           wen_q, wen_d;
    logic [14:0]    adr_q, adr_d;
    logic [31:0]    dat_q, dat_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic           waiting;
    logic           timeout;
    logic [15:0]    n16;

    // Loader state and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_CMD;
            seg_q    <= 1'b0;
            len_lo_q <= '0;
            len_q    <= '0;
            widx_q   <= '0;
            bcnt_q   <= '0;
            word_q   <= '0;
            tcnt_q   <= '0;
            wen_q    <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            seg_q    <= seg_d;
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            widx_q   <= widx_d;
            bcnt_q   <= bcnt_d;
            word_q   <= word_d;
            tcnt_q   <= tcnt_d;
            wen_q    <= wen_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign waiting = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA);
    // Expiry is checked before the byte, so a byte landing on the expiry clock is lost
    assign timeout = waiting && (tcnt_q == TMAX);
    assign n16     = {rx_byte, len_lo_q};

    // Frame parser: command, little-endian length, then little-endian words
    always_comb begin
        state_d  = state_q;
        seg_d    = seg_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        widx_d   = widx_q;
        bcnt_d   = bcnt_q;
        word_d   = word_q;
        tcnt_d   = '0;
        wen_d    = 1'b0;
        adr_d    = adr_q;
        dat_d    = dat_q;
        done_d   = done_q;
        err_d    = err_q;

        if (rx_ferr) begin
            err_d = 1'b1;
        end

        if (waiting && !rx_valid) begin
            tcnt_d = tcnt_q + TW'(1);
        end

        if (timeout) begin
            state_d = S_CMD;
            bcnt_d  = '0;
            err_d   = 1'b1;
            tcnt_d  = '0;
        end else if (rx_valid) begin
            case (state_q)
                S_CMD: begin
                    case (rx_byte)
                        CMD_IROM: begin
                            seg_d   = 1'b0;
                            state_d = S_LEN0;
                        end
                        CMD_DRAM: begin
                            seg_d   = 1'b1;
                            state_d = S_LEN0;
                        end
                        CMD_DONE: begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end
                        default: state_d = S_CMD;
                    endcase
                end
                S_LEN0: begin
                    len_lo_d = rx_byte;
                    state_d  = S_LEN1;
                end
                S_LEN1: begin
                    widx_d = '0;
                    bcnt_d = '0;
                    if (n16 == 16'd0) begin
                        state_d = S_CMD;
                    end else if (n16 > MAX_N16) begin
                        len_d   = 15'(MAX_WORDS);
                        err_d   = 1'b1;
                        state_d = S_DATA;
                    end else begin
                        len_d   = n16[14:0];
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    word_d = {rx_byte, word_q[31:8]};
                    if (bcnt_q == 2'd3) begin
                        wen_d  = 1'b1;
                        adr_d  = {seg_q, widx_q[13:0]};
                        dat_d  = {rx_byte, word_q[31:8]};
                        bcnt_d = '0;
                        widx_d = widx_q + 15'd1;
                        if (widx_q + 15'd1 == len_q) begin
                            state_d = S_CMD;
                        end
                    end else begin
                        bcnt_d = bcnt_q + 2'd1;
                    end
                end
                S_DONE:  state_d = S_DONE;
                default: state_d = S_CMD;
            endcase
        end
    end

    assign upg_wen_o  = wen_q;
    assign upg_adr_o  = adr_q;
    assign upg_dat_o  = dat_q;
    assign upg_done_o = done_q;
    assign upg_err_o  = err_q;
    assign busy_o     = (state_q != S_CMD) && (state_q != S_DONE);

endmodule
